// File: rtl/bytecode_fetch_unit_if.sv
// Bus bundle between the fetch unit, program memory and the decode stage.
// The master side is the fetch unit itself; the slave side is whatever
// surrounds it (memory model plus decode stage).
interface bytecode_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int ARGS   = 2,
  parameter int DEPTH  = 8
);
  localparam int CL_W  = $clog2(ARGS + 2);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic                mem_rd;
  logic [ADDR_W-1:0]   mem_addr;
  logic [7:0]          mem_data;
  logic [7:0]          op_code;
  logic [8*ARGS-1:0]   args;
  logic                window_valid;
  logic [ADDR_W-1:0]   program_counter;
  logic                consume;
  logic [CL_W-1:0]     consume_len;
  logic                jump;
  logic [ADDR_W-1:0]   jump_target;
  logic [LVL_W-1:0]    level;

  modport master (
    output mem_rd, mem_addr, op_code, args, window_valid, program_counter, level,
    input  mem_data, consume, consume_len, jump, jump_target
  );

  modport slave (
    input  mem_rd, mem_addr, op_code, args, window_valid, program_counter, level,
    output mem_data, consume, consume_len, jump, jump_target
  );
endinterface

// File: rtl/bytecode_fetch_unit.sv
// Prefetching instruction front end for the bytecode CPU. Bytes stream from a
// one-cycle synchronous program memory into a small circular byte buffer; the
// decode stage sees the opcode and ARGS argument bytes at program_counter and
// retires a variable number of bytes per cycle or redirects with a jump.
module bytecode_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int ARGS   = 2,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bytecode_fetch_unit_if.master    bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int CL_W  = $clog2(ARGS + 2);

  localparam logic [LVL_W:0]   OCC_FULL = (LVL_W + 1)'(DEPTH);
  localparam logic [LVL_W-1:0] WIN_NEED = LVL_W'(ARGS + 1);
  localparam logic [CL_W-1:0]  LEN_MAX  = CL_W'(ARGS + 1);

  logic [7:0]        r_buf [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [LVL_W-1:0]  r_level;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_fetchAddr;
  logic              r_inflight;

  logic [LVL_W:0]    w_occupancy;
  logic              w_issue;
  logic              w_write;
  logic              w_windowValid;
  logic              w_accept;
  logic [LVL_W-1:0]  w_retire;
  logic [7:0]        w_opCode;
  logic [8*ARGS-1:0] w_args;

  // Space is reserved for the read still in flight, so the buffer can never
  // overflow. Reads are held off while in reset so mem_rd reads 0 immediately.
  assign w_occupancy   = {1'b0, r_level} + {{LVL_W{1'b0}}, r_inflight};
  assign w_issue       = rst_n && (w_occupancy < OCC_FULL);
  assign w_write       = r_inflight && !bus.jump;
  assign w_windowValid = (r_level >= WIN_NEED);
  assign w_accept      = w_windowValid && bus.consume && !bus.jump &&
                         (bus.consume_len != '0) && (bus.consume_len <= LEN_MAX);
  assign w_retire      = w_accept ? LVL_W'(bus.consume_len) : '0;

  // Window bytes are read straight out of the buffer starting at head,
  // wrapping around the circular storage; zero whenever the window is short.
  always_comb begin
    w_opCode = '0;
    w_args   = '0;
    if (w_windowValid) begin
      w_opCode = r_buf[r_head];
      for (int i = 0; i < ARGS; i++) begin
        w_args[8*i +: 8] = r_buf[r_head + PTR_W'(i + 1)];
      end
    end
  end

  // Returned memory bytes land at tail at the end of their data cycle; data
  // from a read squashed by a jump is dropped here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_write) begin
      r_buf[r_tail] <= bus.mem_data;
    end
  end

  // Pointer, level, program counter and fetch address bookkeeping. A jump
  // flushes the buffer by snapping head onto tail and restarts fetching at the
  // target; otherwise retire and fill are applied together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_level     <= '0;
      r_pc        <= '0;
      r_fetchAddr <= '0;
      r_inflight  <= 1'b0;
    end else if (bus.jump) begin
      r_head      <= r_tail;
      r_level     <= '0;
      r_pc        <= bus.jump_target;
      r_fetchAddr <= bus.jump_target;
      r_inflight  <= 1'b0;
    end else begin
      r_head      <= r_head + PTR_W'(w_retire);
      r_pc        <= r_pc + ADDR_W'(w_retire);
      r_level     <= r_level - w_retire + {{(LVL_W-1){1'b0}}, w_write};
      r_inflight  <= w_issue;
      if (w_write) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_issue) begin
        r_fetchAddr <= r_fetchAddr + ADDR_W'(1);
      end
    end
  end

  assign bus.mem_rd          = w_issue;
  assign bus.mem_addr        = r_fetchAddr;
  assign bus.op_code         = w_opCode;
  assign bus.args            = w_args;
  assign bus.window_valid    = w_windowValid;
  assign bus.program_counter = r_pc;
  assign bus.level           = r_level;
endmodule

// File: tb/tb_bytecode_fetch_unit.sv
// Bench for bytecode_fetch_unit: directed scenarios with literal expectations
// followed by randomized consume/jump traffic, all checked every cycle against
// a byte-count model of the fetch front end.
module tb_bytecode_fetch_unit;
  localparam int ADDR_W = 16;
  localparam int ARGS   = 2;
  localparam int DEPTH  = 8;
  localparam int CL_W   = $clog2(ARGS + 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  // Reference model state: only spec-level quantities, no buffer storage.
  int   mPc = 0;
  int   mFetch = 0;
  int   mLevel = 0;
  bit   mInflight = 1'b0;

  always #5 clk = ~clk;

  bytecode_fetch_unit_if #(.ADDR_W(ADDR_W), .ARGS(ARGS), .DEPTH(DEPTH)) bus ();

  bytecode_fetch_unit #(.ADDR_W(ADDR_W), .ARGS(ARGS), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Program memory contents: mem[a] = (a + 0x10) & 0xFF.
  function automatic logic [7:0] patternByte(input int a);
    int s;
    s = (a + 16'h10) & 8'hFF;
    return 8'(s);
  endfunction

  function automatic bit modelValid();
    return mLevel >= ARGS + 1;
  endfunction

  function automatic bit modelIssue();
    return (mLevel + int'(mInflight)) < DEPTH;
  endfunction

  function automatic int modelRetire();
    int len;
    len = int'(bus.consume_len);
    if (modelValid() && bus.consume && !bus.jump && len >= 1 && len <= ARGS + 1) return len;
    return 0;
  endfunction

  function automatic logic [7:0] expOp();
    return modelValid() ? patternByte(mPc) : 8'h00;
  endfunction

  function automatic logic [8*ARGS-1:0] expArgs();
    logic [8*ARGS-1:0] r;
    r = '0;
    if (modelValid()) begin
      for (int i = 0; i < ARGS; i++) r[8*i +: 8] = patternByte((mPc + 1 + i) & 16'hFFFF);
    end
    return r;
  endfunction

  // One-cycle synchronous program memory.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_data <= patternByte(int'(bus.mem_addr));
  end

  // Model advance at each edge following the fetch/consume/jump rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPc       <= 0;
      mFetch    <= 0;
      mLevel    <= 0;
      mInflight <= 1'b0;
    end else if (bus.jump) begin
      mPc       <= int'(bus.jump_target);
      mFetch    <= int'(bus.jump_target);
      mLevel    <= 0;
      mInflight <= 1'b0;
    end else begin
      mPc       <= (mPc + modelRetire()) & 16'hFFFF;
      mLevel    <= mLevel - modelRetire() + int'(mInflight);
      mFetch    <= modelIssue() ? ((mFetch + 1) & 16'hFFFF) : mFetch;
      mInflight <= modelIssue();
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit c, input int len, input bit j, input int target);
    bus.consume     = c;
    bus.consume_len = CL_W'(len);
    bus.jump        = j;
    bus.jump_target = ADDR_W'(target);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_valid"}, 64'(bus.window_valid), 64'(0));
    checkOutput({tag, "_op"},    64'(bus.op_code), 64'(0));
    checkOutput({tag, "_args"},  64'(bus.args), 64'(0));
    checkOutput({tag, "_pc"},    64'(bus.program_counter), 64'(0));
    checkOutput({tag, "_level"}, 64'(bus.level), 64'(0));
    checkOutput({tag, "_mem_rd"}, 64'(bus.mem_rd), 64'(0));
  endtask

  // Per-cycle comparison against the model, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("model_valid", 64'(bus.window_valid), 64'(modelValid()));
      checkOutput("model_op",    64'(bus.op_code), 64'(expOp()));
      checkOutput("model_args",  64'(bus.args), 64'(expArgs()));
      checkOutput("model_pc",    64'(bus.program_counter), 64'(mPc));
      checkOutput("model_level", 64'(bus.level), 64'(mLevel));
      checkOutput("model_mem_rd", 64'(bus.mem_rd), 64'(modelIssue()));
      if (modelIssue()) checkOutput("model_mem_addr", 64'(bus.mem_addr), 64'(mFetch));
    end
  end

  // Directed scenarios, randomized traffic, then streaming with a mid-cycle reset.
  initial begin
    int r;
    applyStimulus(0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkReset("in_reset");

    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checkOutput("first_rd", 64'(bus.mem_rd), 64'(1));
        checkOutput("first_addr", 64'(bus.mem_addr), 64'(0));
      end
      if (k < 4) begin
        checkOutput($sformatf("fill_valid_c%0d", k), 64'(bus.window_valid), 64'(0));
      end else begin
        checkOutput("fill_valid_c4", 64'(bus.window_valid), 64'(1));
        checkOutput("fill_op", 64'(bus.op_code), 64'(8'h10));
        checkOutput("fill_args", 64'(bus.args), 64'(16'h1211));
        checkOutput("fill_pc", 64'(bus.program_counter), 64'(0));
      end
    end
    repeat (8) @(negedge clk);
    checkOutput("full_level", 64'(bus.level), 64'(8));
    checkOutput("full_mem_rd", 64'(bus.mem_rd), 64'(0));
    checkOutput("full_fetch_addr", 64'(bus.mem_addr), 64'(8));

    applyStimulus(1, 1, 0, 0);
    @(negedge clk);
    checkOutput("c1_pc", 64'(bus.program_counter), 64'(1));
    checkOutput("c1_op", 64'(bus.op_code), 64'(8'h11));
    applyStimulus(1, 3, 0, 0);
    @(negedge clk);
    checkOutput("c3_pc", 64'(bus.program_counter), 64'(4));
    checkOutput("c3_op", 64'(bus.op_code), 64'(8'h14));
    applyStimulus(1, 2, 0, 0);
    @(negedge clk);
    checkOutput("c2_pc", 64'(bus.program_counter), 64'(6));
    checkOutput("c2_op", 64'(bus.op_code), 64'(8'h16));
    checkOutput("c2_args", 64'(bus.args), 64'(16'h1817));

    applyStimulus(1, 2, 1, 16'h0040);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0);
    checkOutput("jmp_level", 64'(bus.level), 64'(0));
    checkOutput("jmp_valid_t1", 64'(bus.window_valid), 64'(0));
    checkOutput("jmp_pc", 64'(bus.program_counter), 64'(16'h0040));
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      if (k < 5) begin
        checkOutput($sformatf("jmp_valid_t%0d", k), 64'(bus.window_valid), 64'(0));
      end else begin
        checkOutput("jmp_valid_t5", 64'(bus.window_valid), 64'(1));
        checkOutput("jmp_op", 64'(bus.op_code), 64'(8'h50));
        checkOutput("jmp_args", 64'(bus.args), 64'(16'h5251));
        checkOutput("jmp_pc_t5", 64'(bus.program_counter), 64'(16'h0040));
      end
    end

    repeat (10) @(negedge clk);
    applyStimulus(1, 0, 0, 0);
    @(negedge clk);
    checkOutput("len0_pc", 64'(bus.program_counter), 64'(16'h0040));
    checkOutput("len0_level", 64'(bus.level), 64'(8));
    checkOutput("len0_op", 64'(bus.op_code), 64'(8'h50));
    applyStimulus(1, 4, 0, 0);
    @(negedge clk);
    checkOutput("len4_pc", 64'(bus.program_counter), 64'(16'h0040));
    checkOutput("len4_level", 64'(bus.level), 64'(8));
    checkOutput("len4_args", 64'(bus.args), 64'(16'h5251));

    applyStimulus(0, 0, 1, 16'hFFFE);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0);
    repeat (4) @(negedge clk);
    checkOutput("wrap_valid", 64'(bus.window_valid), 64'(1));
    checkOutput("wrap_op", 64'(bus.op_code), 64'(8'h0E));
    checkOutput("wrap_args", 64'(bus.args), 64'(16'h100F));
    checkOutput("wrap_pc", 64'(bus.program_counter), 64'(16'hFFFE));
    applyStimulus(1, 3, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0);
    checkOutput("wrap_consume_pc", 64'(bus.program_counter), 64'(16'h0001));

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      r = $urandom_range(0, 99);
      if (r < 3) begin
        applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 3), 1,
                      (r == 0) ? $urandom_range(16'hFFF8, 16'hFFFF) : $urandom_range(0, 16'hFFFF));
      end else begin
        applyStimulus(r < 75, $urandom_range(0, 3), 0, 0);
      end
    end

    @(negedge clk);
    applyStimulus(0, 0, 0, 0);
    repeat (14) @(negedge clk);
    for (int n = 0; n < 15; n++) begin
      applyStimulus(1, 1, 0, 0);
      @(negedge clk);
      checkOutput($sformatf("stream_valid_%0d", n), 64'(bus.window_valid), 64'(1));
    end

    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 checkReset("mid_reset");
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("refetch_rd", 64'(bus.mem_rd), 64'(1));
    checkOutput("refetch_addr", 64'(bus.mem_addr), 64'(0));
    repeat (6) @(negedge clk);
    checkOutput("refetch_op", 64'(bus.op_code), 64'(8'h10));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
